// File: rtl/jtgng_dwnld_pkg.sv
// Shared types and constants for the ROM-download SDRAM writer.
package jtgng_dwnld_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } wr_st_e;

    localparam logic [1:0] DQM_NONE = 2'b11;
    localparam logic [1:0] DQM_LO   = 2'b10;
    localparam logic [1:0] DQM_HI   = 2'b01;
    localparam logic [1:0] DQM_BOTH = 2'b00;

    // FIFO entry is {word address, data, mask}
    function automatic int entry_w(input int aw);
        return aw - 1 + 16 + 2;
    endfunction

endpackage

// File: rtl/jtgng_dwnld_fifo.sv
// Small synchronous word FIFO; a push while full is accepted only if a pop frees a slot.
module jtgng_dwnld_fifo #(
    parameter int W     = 39,
    parameter int DEPTH = 4
) (
    input  logic         clk_rom,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic [PW:0]   cnt;
    logic          wr_ok, rd_ok;

    assign full  = cnt == (PW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign wr_ok = push & (~full | pop);
    assign rd_ok = pop & ~empty;
    assign dout  = mem[rp];

    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (wr_ok) wp <= wp + 1'b1;
            if (rd_ok) rp <= rp + 1'b1;
            cnt <= cnt + (PW+1)'(wr_ok) - (PW+1)'(rd_ok);
        end
    end

    always_ff @(posedge clk_rom) begin
        if (wr_ok) mem[wp] <= din;
    end

endmodule

// File: rtl/jtgng_dwnld_sdram_writer.sv
// Packs ioctl download bytes into masked 16-bit SDRAM writes through a word FIFO.
// Define DWNLD_HEADER_EN to strip the first HEADER_LEN bytes of the stream.
module jtgng_dwnld_sdram_writer
    import jtgng_dwnld_pkg::*;
#(
    parameter int AW         = 22,
    parameter int FIFO_DEPTH = 4,
    parameter int HEADER_LEN = 16
) (
    input  logic          clk_rom,
    input  logic          rst_n,
    input  logic          downloading,
    input  logic [AW-1:0] ioctl_addr,
    input  logic [7:0]    ioctl_data,
    input  logic          ioctl_wr,
    output logic          sdram_req,
    output logic [AW-2:0] sdram_addr,
    output logic [15:0]   sdram_din,
    output logic [1:0]    sdram_dqm_n,
    input  logic          sdram_ack,
    output logic          done,
    output logic          overflow
);
    localparam int EW = entry_w(AW);

    logic          dl_q, dl_rise, seen;
    logic          wr_eff;
    logic [AW-1:0] a;
    logic          pend_v, pend_vlo, pend_vhi, pend_live, hit;
    logic [AW-2:0] pend_waddr;
    logic [7:0]    pend_lo, pend_hi;
    logic          nv, nvlo, nvhi;
    logic [AW-2:0] nwaddr;
    logic [7:0]    nlo, nhi;
    logic          push, pop, full, empty;
    logic [EW-1:0] push_ent, part_ent, head;
    logic [1:0]    part_dqm;
    wr_st_e        st, st_nxt;

`ifdef DWNLD_HEADER_EN
    localparam logic [AW-1:0] HDR = AW'(HEADER_LEN);
    assign wr_eff = ioctl_wr & (ioctl_addr >= HDR);
    assign a      = ioctl_addr - HDR;
`else
    assign wr_eff = ioctl_wr;
    assign a      = ioctl_addr;
`endif

    assign dl_rise   = downloading & ~dl_q;
    assign pend_live = pend_v & ~dl_rise;
    assign hit       = pend_live & (pend_waddr == a[AW-1:1]);
    assign pop       = (st == ST_REQ) & sdram_ack;

    always_comb begin
        part_dqm = pend_vlo & pend_vhi ? DQM_BOTH :
                   pend_vlo            ? DQM_LO   :
                   pend_vhi            ? DQM_HI   : DQM_NONE;
        part_ent = {pend_waddr, pend_vhi ? pend_hi : 8'd0, pend_vlo ? pend_lo : 8'd0, part_dqm};
    end

    // At most one push per cycle: a flush racing a new byte keeps the byte pending
    always_comb begin
        push     = 1'b0;
        push_ent = part_ent;
        nv       = pend_live;
        nwaddr   = pend_waddr;
        nlo      = pend_lo;
        nhi      = pend_hi;
        nvlo     = pend_vlo;
        nvhi     = pend_vhi;
        if (wr_eff) begin
            if (hit) begin
                if (a[0]) begin nhi = ioctl_data; nvhi = 1'b1; end
                else      begin nlo = ioctl_data; nvlo = 1'b1; end
                if (nvlo && nvhi) begin
                    push     = 1'b1;
                    push_ent = {pend_waddr, nhi, nlo, DQM_BOTH};
                    nv       = 1'b0;
                end
            end else begin
                push   = pend_live;
                nv     = 1'b1;
                nwaddr = a[AW-1:1];
                nlo    = ioctl_data;
                nhi    = ioctl_data;
                nvlo   = ~a[0];
                nvhi   = a[0];
            end
        end else if (!downloading && pend_v) begin
            push = 1'b1;
            nv   = 1'b0;
        end
    end

    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            dl_q       <= 1'b0;
            seen       <= 1'b0;
            pend_v     <= 1'b0;
            pend_vlo   <= 1'b0;
            pend_vhi   <= 1'b0;
            pend_waddr <= '0;
            pend_lo    <= '0;
            pend_hi    <= '0;
            overflow   <= 1'b0;
            done       <= 1'b0;
        end else begin
            dl_q       <= downloading;
            seen       <= seen | dl_rise;
            pend_v     <= nv;
            pend_vlo   <= nvlo;
            pend_vhi   <= nvhi;
            pend_waddr <= nwaddr;
            pend_lo    <= nlo;
            pend_hi    <= nhi;
            if (dl_rise)                  overflow <= 1'b0;
            else if (push && full && !pop) overflow <= 1'b1;
            done <= ~downloading & seen & ~pend_v & ~push & empty & (st == ST_IDLE);
        end
    end

    jtgng_dwnld_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_rom (clk_rom),
        .rst_n   (rst_n),
        .push    (push),
        .din     (push_ent),
        .pop     (pop),
        .dout    (head),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        st_nxt = st;
        case (st)
            ST_IDLE: if (!empty)   st_nxt = ST_REQ;
            ST_REQ:  if (sdram_ack) st_nxt = ST_GAP;
            default:               st_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) st <= ST_IDLE;
        else        st <= st_nxt;
    end

    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            sdram_req   <= 1'b0;
            sdram_addr  <= '0;
            sdram_din   <= '0;
            sdram_dqm_n <= DQM_NONE;
        end else if (st == ST_IDLE && !empty) begin
            {sdram_addr, sdram_din, sdram_dqm_n} <= head;
            sdram_req <= 1'b1;
        end else if (pop) begin
            sdram_req <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jtgng_dwnld_sdram_writer.sv
// Directed bench for the download SDRAM writer: vector table plus corner-case sequences.
module tb_jtgng_dwnld_sdram_writer;
    localparam int AW = 22;
    localparam int FD = 4;
`ifdef DWNLD_HEADER_EN
    localparam logic [21:0] OFS = 22'd16;
`else
    localparam logic [21:0] OFS = 22'd0;
`endif

    logic        clk_rom = 1'b0, rst_n = 1'b0;
    logic        downloading = 1'b0, ioctl_wr = 1'b0, sdram_ack = 1'b0;
    logic [21:0] ioctl_addr = '0;
    logic [7:0]  ioctl_data = '0;
    logic        sdram_req, done, overflow;
    logic [20:0] sdram_addr;
    logic [15:0] sdram_din;
    logic [1:0]  sdram_dqm_n;

    jtgng_dwnld_sdram_writer #(.AW(AW), .FIFO_DEPTH(FD), .HEADER_LEN(16)) dut (
        .clk_rom(clk_rom), .rst_n(rst_n), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_din(sdram_din),
        .sdram_dqm_n(sdram_dqm_n), .sdram_ack(sdram_ack), .done(done), .overflow(overflow)
    );

    always #5 clk_rom = ~clk_rom;

    typedef struct {
        logic [20:0] addr;
        logic [15:0] din;
        logic [1:0]  dqm;
    } rec_t;

    typedef struct {
        int          nb;
        logic [21:0] a0, a1;
        logic [7:0]  d0, d1;
        int          nw;
        logic [20:0] wa0, wa1;
        logic [15:0] wd0, wd1;
        logic [1:0]  wm0, wm1;
    } vec_t;

    rec_t q[$];
    logic ack_en = 1'b0;
    int   n_vec = 0, n_fail = 0;

    // Zero-wait ack responder; records every write the DUT gets accepted
    always @(negedge clk_rom) begin
        if (sdram_ack) sdram_ack = 1'b0;
        else if (ack_en && sdram_req && rst_n) begin
            sdram_ack = 1'b1;
            q.push_back('{sdram_addr, sdram_din, sdram_dqm_n});
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [21:0] addr, input logic [7:0] data);
        @(negedge clk_rom);
        ioctl_wr = 1'b1; ioctl_addr = addr; ioctl_data = data;
        @(negedge clk_rom);
        ioctl_wr = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        for (k = 0; k < 200; k++) begin
            @(posedge clk_rom); #1;
            if (done) break;
        end
        check({name, "_done"}, {31'd0, done}, 32'd1);
    endtask

    function automatic logic [15:0] lane_mask(input logic [1:0] m);
        return {{8{~m[1]}}, {8{~m[0]}}};
    endfunction

    task automatic check_wr(input string name, input int idx, input logic [20:0] wa,
                            input logic [15:0] wd, input logic [1:0] wm);
        if (idx >= q.size()) begin
            check({name, "_present"}, 32'(q.size()), 32'(idx + 1));
        end else begin
            check({name, "_addr"}, 32'(q[idx].addr), 32'(wa));
            check({name, "_dqm"},  32'(q[idx].dqm),  32'(wm));
            check({name, "_din"},  32'(q[idx].din & lane_mask(wm)), 32'(wd & lane_mask(wm)));
        end
    endtask

    vec_t vt[6];

    initial begin
        vt[0] = '{2, 22'd0, 22'd1, 8'h11, 8'h22, 1, 21'd0, 21'd0, 16'h2211, 16'h0, 2'b00, 2'b00};
        vt[1] = '{1, 22'd7, 22'd0, 8'h5A, 8'h00, 1, 21'd3, 21'd0, 16'h5A00, 16'h0, 2'b01, 2'b00};
        vt[2] = '{2, 22'd4, 22'd9, 8'hAB, 8'hCD, 2, 21'd2, 21'd4, 16'h00AB, 16'hCD00, 2'b10, 2'b01};
        vt[3] = '{2, 22'd3, 22'd2, 8'h33, 8'h44, 1, 21'd1, 21'd0, 16'h3344, 16'h0, 2'b00, 2'b00};
        vt[4] = '{2, 22'd6, 22'd6, 8'h01, 8'h02, 1, 21'd3, 21'd0, 16'h0002, 16'h0, 2'b10, 2'b00};
        vt[5] = '{1, 22'h3FFFEF, 22'd0, 8'h77, 8'h00, 1, 21'h1FFFF7, 21'd0, 16'h7700, 16'h0, 2'b01, 2'b00};

        #12;
        check("rst_req",  {31'd0, sdram_req}, 32'd0);
        check("rst_addr", 32'(sdram_addr), 32'd0);
        check("rst_din",  32'(sdram_din), 32'd0);
        check("rst_dqm",  32'(sdram_dqm_n), 32'd3);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ovf",  {31'd0, overflow}, 32'd0);
        @(negedge clk_rom); rst_n = 1'b1;

        // Latency: completing byte at cycle 0, request visible in cycle 2
        @(negedge clk_rom); downloading = 1'b1;
        send(OFS + 22'd0, 8'h11);
        @(negedge clk_rom);
        ioctl_wr = 1'b1; ioctl_addr = OFS + 22'd1; ioctl_data = 8'h22;
        @(posedge clk_rom); #1;
        check("lat_c1_req", {31'd0, sdram_req}, 32'd0);
        @(negedge clk_rom); ioctl_wr = 1'b0;
        @(posedge clk_rom); #1;
        check("lat_c2_req",  {31'd0, sdram_req}, 32'd1);
        check("lat_c2_addr", 32'(sdram_addr), 32'd0);
        check("lat_c2_din",  32'(sdram_din), 32'h2211);
        check("lat_c2_dqm",  32'(sdram_dqm_n), 32'd0);
        @(negedge clk_rom); ack_en = 1'b1; downloading = 1'b0;
        wait_done("lat");
        check("lat_nwr", 32'(q.size()), 32'd1);

        foreach (vt[i]) begin
            q.delete();
            @(negedge clk_rom); downloading = 1'b1;
            @(posedge clk_rom); #1;
            check($sformatf("v%0d_done_lo", i), {31'd0, done}, 32'd0);
            send(vt[i].a0 + OFS, vt[i].d0);
            if (vt[i].nb > 1) send(vt[i].a1 + OFS, vt[i].d1);
            @(negedge clk_rom); downloading = 1'b0;
            wait_done($sformatf("v%0d", i));
            check($sformatf("v%0d_nwr", i), 32'(q.size()), 32'(vt[i].nw));
            check_wr($sformatf("v%0d_w0", i), 0, vt[i].wa0, vt[i].wd0, vt[i].wm0);
            if (vt[i].nw > 1) check_wr($sformatf("v%0d_w1", i), 1, vt[i].wa1, vt[i].wd1, vt[i].wm1);
            check($sformatf("v%0d_ovf", i), {31'd0, overflow}, 32'd0);
        end

        // Overflow: 64 back-to-back bytes with the SDRAM port stalled
        q.delete();
        @(negedge clk_rom); ack_en = 1'b0; downloading = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk_rom);
            ioctl_wr = 1'b1; ioctl_addr = OFS + 22'(i); ioctl_data = 8'(i);
        end
        @(negedge clk_rom); ioctl_wr = 1'b0;
        @(posedge clk_rom); #1;
        check("ovf_set", {31'd0, overflow}, 32'd1);
        @(negedge clk_rom); ack_en = 1'b1; downloading = 1'b0;
        wait_done("ovf");
        n_vec++;
        if (q.size() < 1 || q.size() > FD + 1) begin
            n_fail++;
            $display("FAIL ovf_nwr: got %0d writes expected 1..%0d", q.size(), FD + 1);
        end
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        if (q.size() > 0) check_wr("ovf_first", 0, 21'd0, 16'h0100, 2'b00);
        @(negedge clk_rom); downloading = 1'b1;
        @(posedge clk_rom); #1;
        check("ovf_clear", {31'd0, overflow}, 32'd0);
        @(negedge clk_rom); downloading = 1'b0;
        wait_done("ovf_end");

`ifdef DWNLD_HEADER_EN
        q.delete();
        @(negedge clk_rom); downloading = 1'b1;
        for (int i = 0; i < 18; i++) send(22'(i), 8'hA0 + 8'(i));
        @(negedge clk_rom); downloading = 1'b0;
        wait_done("hdr");
        check("hdr_nwr", 32'(q.size()), 32'd1);
        check_wr("hdr_w0", 0, 21'd0, 16'hB1B0, 2'b00);
`endif

        // Reset while a request is outstanding
        q.delete();
        @(negedge clk_rom); ack_en = 1'b0; downloading = 1'b1;
        send(OFS + 22'd10, 8'hEE);
        send(OFS + 22'd11, 8'hFF);
        @(negedge clk_rom); downloading = 1'b0;
        begin
            int k;
            for (k = 0; k < 20; k++) begin
                @(posedge clk_rom); #1;
                if (sdram_req) break;
            end
            check("rstm_req_up", {31'd0, sdram_req}, 32'd1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("rstm_req_async", {31'd0, sdram_req}, 32'd0);
        check("rstm_done",      {31'd0, done}, 32'd0);
        @(negedge clk_rom); rst_n = 1'b1; ack_en = 1'b1;
        repeat (20) @(posedge clk_rom);
        #1;
        check("rstm_nwr",       32'(q.size()), 32'd0);
        check("rstm_req_after", {31'd0, sdram_req}, 32'd0);
        check("rstm_done_after", {31'd0, done}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
